// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM stepping FETCH/DECODE/execute per opcode.
// Latency: outputs decode the current state combinationally; illegal_op lags DECODE by one cycle.
// Backpressure: stall freezes the state and forces a bubble (all control outputs zero).
module mc_control_fsm #(
  parameter logic [5:0] OP_LW   = 6'h23,
  parameter logic [5:0] OP_SW   = 6'h2B,
  parameter logic [5:0] OP_BEQ  = 6'h04,
  parameter logic [5:0] OP_J    = 6'h02,
  parameter logic [5:0] OP_ADDI = 6'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        stall,
  input  logic [5:0]  opcode,
  output logic [12:0] ctrl_word,
  output logic [3:0]  alu_ctl,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'h00;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    WB_R     = 4'd8,
    EXEC_I   = 4'd9,
    WB_I     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  state_t      state_q;
  state_t      state_nxt;
  logic        illegal_nxt;
  logic [12:0] ctrl_raw;
  logic [3:0]  alu_raw;
  logic        done_raw;

  // State register and the one-cycle illegal-opcode pulse; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      illegal_op <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      illegal_op <= illegal_nxt;
    end
  end

  // Next-state and per-state control decode; stall holds state and zeroes every output.
  always_comb begin
    state_nxt   = state_q;
    illegal_nxt = 1'b0;
    ctrl_raw    = 13'h0000;
    alu_raw     = 4'b0000;
    done_raw    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        ctrl_raw  = 13'h04A0;
        alu_raw   = 4'b0100;
        state_nxt = DECODE;
      end
      DECODE: begin
        alu_raw = 4'b1100;
        if (opcode == OP_RTYPE)                        state_nxt = EXEC_R;
        else if (opcode == OP_LW || opcode == OP_SW)   state_nxt = MEM_ADDR;
        else if (opcode == OP_BEQ)                     state_nxt = BRANCH;
        else if (opcode == OP_J)                       state_nxt = JUMP;
        else if (opcode == OP_ADDI)                    state_nxt = EXEC_I;
        else begin
          state_nxt   = IDLE;
          illegal_nxt = 1'b1;
        end
      end
      MEM_ADDR: begin
        ctrl_raw  = 13'h0002;
        alu_raw   = 4'b1000;
        // Opcode is still held in IR, so it picks load vs store here.
        state_nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ctrl_raw  = 13'h0180;
        state_nxt = MEM_WB;
      end
      MEM_WB: begin
        ctrl_raw  = 13'h0014;
        done_raw  = 1'b1;
        state_nxt = run ? FETCH : IDLE;
      end
      MEM_WR: begin
        ctrl_raw  = 13'h0140;
        done_raw  = 1'b1;
        state_nxt = run ? FETCH : IDLE;
      end
      EXEC_R: begin
        ctrl_raw  = 13'h0002;
        alu_raw   = 4'b0010;
        state_nxt = WB_R;
      end
      WB_R: begin
        ctrl_raw  = 13'h000C;
        done_raw  = 1'b1;
        state_nxt = run ? FETCH : IDLE;
      end
      EXEC_I: begin
        ctrl_raw  = 13'h0002;
        alu_raw   = 4'b1000;
        state_nxt = WB_I;
      end
      WB_I: begin
        ctrl_raw  = 13'h0004;
        done_raw  = 1'b1;
        state_nxt = run ? FETCH : IDLE;
      end
      BRANCH: begin
        ctrl_raw  = 13'h0A02;
        alu_raw   = 4'b0001;
        done_raw  = 1'b1;
        state_nxt = run ? FETCH : IDLE;
      end
      JUMP: begin
        ctrl_raw  = 13'h1400;
        done_raw  = 1'b1;
        state_nxt = run ? FETCH : IDLE;
      end
      default: begin
        // Codes 13-15 are unreachable in normal operation; recover to IDLE quietly.
        state_nxt = IDLE;
      end
    endcase

    if (stall) begin
      state_nxt   = state_q;
      illegal_nxt = 1'b0;
    end
  end

  // Bubble gating: a stalled cycle presents an all-zero control word.
  always_comb begin
    ctrl_word  = stall ? 13'h0000 : {ctrl_raw[12:1], 1'b0};
    alu_ctl    = stall ? 4'b0000  : alu_raw;
    instr_done = done_raw & ~stall;
    state      = state_q;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        stall;
  logic [5:0]  opcode;
  logic [12:0] ctrl_word;
  logic [3:0]  alu_ctl;
  logic [3:0]  state;
  logic        instr_done;
  logic        illegal_op;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        run;
    logic        stall;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [12:0] ctrl;
    logic [3:0]  alu;
    logic        done;
    logic        ill;
  } vec_t;

  vec_t        vecs[$];
  logic [22:0] sb[$];

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .stall      (stall),
    .opcode     (opcode),
    .ctrl_word  (ctrl_word),
    .alu_ctl    (alu_ctl),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic rn, input logic stl, input logic [5:0] op,
                              input logic [3:0] st, input logic [12:0] ctrl, input logic [3:0] alu,
                              input logic done, input logic ill);
    vec_t v;
    v.rst = rst; v.run = rn; v.stall = stl; v.op = op;
    v.st = st; v.ctrl = ctrl; v.alu = alu; v.done = done; v.ill = ill;
    return v;
  endfunction

  // Drive one cycle's inputs at the falling edge, queue the expected outputs for
  // that cycle, then sample the DUT mid-cycle and compare against the queue head.
  task automatic apply(input string name, input vec_t v);
    logic [22:0] exp_o;
    logic [22:0] got_o;
    @(negedge clk);
    reset  = v.rst;
    run    = v.run;
    stall  = v.stall;
    opcode = v.op;
    sb.push_back({v.st, v.ctrl, v.alu, v.done, v.ill});
    #2;
    exp_o = sb.pop_front();
    got_o = {state, ctrl_word, alu_ctl, instr_done, illegal_op};
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL %s: got state=%0d ctrl=%h alu=%b done=%b ill=%b, want state=%0d ctrl=%h alu=%b done=%b ill=%b",
               name, got_o[22:19], got_o[18:6], got_o[5:2], got_o[1], got_o[0],
               exp_o[22:19], exp_o[18:6], exp_o[5:2], exp_o[1], exp_o[0]);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; stall = 1'b0; opcode = 6'h00;
    repeat (2) @(posedge clk);

    //           rst run stl op      st     ctrl      alu     done ill
    // Idle after reset, run low for three cycles
    vecs.push_back(mk(0, 0, 0, 6'h00, 4'd0,  13'h0000, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 6'h00, 4'd0,  13'h0000, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 6'h00, 4'd0,  13'h0000, 4'h0, 0, 0));
    // LW: 1,2,3,4,5
    vecs.push_back(mk(0, 1, 0, 6'h23, 4'd0,  13'h0000, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h23, 4'd1,  13'h04A0, 4'h4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h23, 4'd2,  13'h0000, 4'hC, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h23, 4'd3,  13'h0002, 4'h8, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h23, 4'd4,  13'h0180, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h23, 4'd5,  13'h0014, 4'h0, 1, 0));
    // R-type then BEQ back to back
    vecs.push_back(mk(0, 1, 0, 6'h00, 4'd1,  13'h04A0, 4'h4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h00, 4'd2,  13'h0000, 4'hC, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h00, 4'd7,  13'h0002, 4'h2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h00, 4'd8,  13'h000C, 4'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 6'h04, 4'd1,  13'h04A0, 4'h4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h04, 4'd2,  13'h0000, 4'hC, 0, 0));
    vecs.push_back(mk(0, 0, 0, 6'h04, 4'd11, 13'h0A02, 4'h1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 6'h04, 4'd0,  13'h0000, 4'h0, 0, 0));
    // Illegal opcode: back to IDLE with a single-cycle pulse
    vecs.push_back(mk(0, 1, 0, 6'h3F, 4'd0,  13'h0000, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h3F, 4'd1,  13'h04A0, 4'h4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h3F, 4'd2,  13'h0000, 4'hC, 0, 0));
    vecs.push_back(mk(0, 0, 0, 6'h3F, 4'd0,  13'h0000, 4'h0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 6'h3F, 4'd0,  13'h0000, 4'h0, 0, 0));
    // J with a two-cycle stall in DECODE; opcode wobbles while stalled
    vecs.push_back(mk(0, 1, 0, 6'h02, 4'd0,  13'h0000, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h02, 4'd1,  13'h04A0, 4'h4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h02, 4'd2,  13'h0000, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6'h3F, 4'd2,  13'h0000, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 6'h02, 4'd2,  13'h0000, 4'hC, 0, 0));
    vecs.push_back(mk(0, 0, 0, 6'h02, 4'd12, 13'h1400, 4'h0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 6'h02, 4'd0,  13'h0000, 4'h0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in MEM_RD of a load: IDLE next cycle, then run restarts at FETCH
    apply("rst_lw_idle",   mk(0, 1, 0, 6'h23, 4'd0,  13'h0000, 4'h0, 0, 0));
    apply("rst_lw_fetch",  mk(0, 1, 0, 6'h23, 4'd1,  13'h04A0, 4'h4, 0, 0));
    apply("rst_lw_decode", mk(0, 1, 0, 6'h23, 4'd2,  13'h0000, 4'hC, 0, 0));
    apply("rst_lw_addr",   mk(0, 1, 0, 6'h23, 4'd3,  13'h0002, 4'h8, 0, 0));
    apply("rst_lw_memrd",  mk(1, 1, 0, 6'h23, 4'd4,  13'h0180, 4'h0, 0, 0));
    apply("rst_lw_after",  mk(0, 1, 0, 6'h23, 4'd0,  13'h0000, 4'h0, 0, 0));
    apply("rst_lw_restart",mk(0, 1, 0, 6'h23, 4'd1,  13'h04A0, 4'h4, 0, 0));
    // Reset wins over stall
    apply("rst_stall",     mk(1, 1, 1, 6'h23, 4'd2,  13'h0000, 4'h0, 0, 0));
    apply("rst_stall_aft", mk(0, 0, 0, 6'h23, 4'd0,  13'h0000, 4'h0, 0, 0));

    // ADDI with a stall in its final state: instr_done suppressed until released
    apply("addi_idle",     mk(0, 1, 0, 6'h08, 4'd0,  13'h0000, 4'h0, 0, 0));
    apply("addi_fetch",    mk(0, 1, 0, 6'h08, 4'd1,  13'h04A0, 4'h4, 0, 0));
    apply("addi_decode",   mk(0, 1, 0, 6'h08, 4'd2,  13'h0000, 4'hC, 0, 0));
    apply("addi_exec",     mk(0, 1, 0, 6'h08, 4'd9,  13'h0002, 4'h8, 0, 0));
    apply("addi_wb_stall", mk(0, 1, 1, 6'h08, 4'd10, 13'h0000, 4'h0, 0, 0));
    apply("addi_wb",       mk(0, 1, 0, 6'h2B, 4'd10, 13'h0004, 4'h0, 1, 0));

    // SW straight after ADDI: 1,2,3,6
    apply("sw_fetch",      mk(0, 1, 0, 6'h2B, 4'd1,  13'h04A0, 4'h4, 0, 0));
    apply("sw_decode",     mk(0, 1, 0, 6'h2B, 4'd2,  13'h0000, 4'hC, 0, 0));
    apply("sw_addr",       mk(0, 1, 0, 6'h2B, 4'd3,  13'h0002, 4'h8, 0, 0));
    apply("sw_memwr",      mk(0, 0, 0, 6'h2B, 4'd6,  13'h0140, 4'h0, 1, 0));
    apply("sw_idle",       mk(0, 0, 0, 6'h2B, 4'd0,  13'h0000, 4'h0, 0, 0));

    // Illegal opcode while stalled in DECODE must not pulse
    apply("ill_stl_idle",  mk(0, 1, 0, 6'h11, 4'd0,  13'h0000, 4'h0, 0, 0));
    apply("ill_stl_fetch", mk(0, 1, 0, 6'h11, 4'd1,  13'h04A0, 4'h4, 0, 0));
    apply("ill_stl_dec",   mk(0, 1, 1, 6'h11, 4'd2,  13'h0000, 4'h0, 0, 0));
    apply("ill_stl_hold",  mk(0, 1, 0, 6'h11, 4'd2,  13'h0000, 4'hC, 0, 0));
    apply("ill_stl_pulse", mk(0, 0, 0, 6'h11, 4'd0,  13'h0000, 4'h0, 0, 1));
    apply("ill_stl_clear", mk(0, 0, 0, 6'h11, 4'd0,  13'h0000, 4'h0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
